// File: rtl/id_ex_stage_reg_pkg.sv
// Shared pipeline definitions: widths, ALU encodings and the control bundle
// carried through the ID/EX, EX/MEM and MEM/WB registers.
package pipe_defs;

   localparam int XLEN     = 32;
   localparam int REG_AW   = 5;
   localparam int ALUOP_W  = 4;
   localparam int LU_CNT_W = 16;

   typedef enum logic [ALUOP_W-1:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_SLL  = 4'd2,
      ALU_SLT  = 4'd3,
      ALU_SLTU = 4'd4,
      ALU_XOR  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_OR   = 4'd8,
      ALU_AND  = 4'd9,
      ALU_LUI  = 4'd10
   } alu_op_e;

   // Field order is shared by every downstream pipeline register.
   typedef struct packed {
      logic               reg_write;
      logic               mem_read;
      logic               mem_write;
      logic               mem_to_reg;
      logic               alu_src;
      logic [ALUOP_W-1:0] alu_op;
   } ctrl_t;

   localparam ctrl_t CTRL_BUBBLE = '0;

   typedef struct packed {
      logic [XLEN-1:0]   pc;
      logic [REG_AW-1:0] rs1;
      logic [REG_AW-1:0] rs2;
      logic [REG_AW-1:0] rd;
      logic              use_rs1;
      logic              use_rs2;
      logic [XLEN-1:0]   rs1_data;
      logic [XLEN-1:0]   rs2_data;
      logic [XLEN-1:0]   imm;
   } data_t;

   typedef enum logic [1:0] {
      ACT_CAPTURE,
      ACT_HOLD,
      ACT_FLUSH,
      ACT_STALL
   } stage_act_e;

endpackage

// File: rtl/id_ex_stage_reg_if.sv
// ID/EX boundary bundle: decoded ID fields in, registered EX fields and
// pipeline write-enables out.
interface id_ex_stage_reg_if #(parameter int CNT_W = 16);
   import pipe_defs::*;

   logic                valid_ID;
   logic [XLEN-1:0]     PC_ID;
   logic [REG_AW-1:0]   RS1_ID;
   logic [REG_AW-1:0]   RS2_ID;
   logic [REG_AW-1:0]   RD_ID;
   logic                useRs1_ID;
   logic                useRs2_ID;
   logic [XLEN-1:0]     rs1Data_ID;
   logic [XLEN-1:0]     rs2Data_ID;
   logic [XLEN-1:0]     imm_ID;
   logic                regWrite_ID;
   logic                memRead_ID;
   logic                memWrite_ID;
   logic                memToReg_ID;
   logic                aluSrc_ID;
   logic [ALUOP_W-1:0]  aluOp_ID;
   logic                hold_ext;
   logic                flush_EX;

   logic                valid_EX;
   logic [XLEN-1:0]     PC_EX;
   logic [REG_AW-1:0]   RS1_EX;
   logic [REG_AW-1:0]   RS2_EX;
   logic [REG_AW-1:0]   RD_EX;
   logic                useRs1_EX;
   logic                useRs2_EX;
   logic [XLEN-1:0]     rs1Data_EX;
   logic [XLEN-1:0]     rs2Data_EX;
   logic [XLEN-1:0]     imm_EX;
   logic                regWrite_EX;
   logic                memRead_EX;
   logic                memWrite_EX;
   logic                memToReg_EX;
   logic                aluSrc_EX;
   logic [ALUOP_W-1:0]  aluOp_EX;
   logic                ID_EX_WE;
   logic                PC_WE;
   logic                IF_ID_WE;
   logic [CNT_W-1:0]    luStallCnt;

   modport master (
      output valid_ID, PC_ID, RS1_ID, RS2_ID, RD_ID, useRs1_ID, useRs2_ID,
             rs1Data_ID, rs2Data_ID, imm_ID, regWrite_ID, memRead_ID,
             memWrite_ID, memToReg_ID, aluSrc_ID, aluOp_ID, hold_ext, flush_EX,
      input  valid_EX, PC_EX, RS1_EX, RS2_EX, RD_EX, useRs1_EX, useRs2_EX,
             rs1Data_EX, rs2Data_EX, imm_EX, regWrite_EX, memRead_EX,
             memWrite_EX, memToReg_EX, aluSrc_EX, aluOp_EX,
             ID_EX_WE, PC_WE, IF_ID_WE, luStallCnt
   );

   modport slave (
      input  valid_ID, PC_ID, RS1_ID, RS2_ID, RD_ID, useRs1_ID, useRs2_ID,
             rs1Data_ID, rs2Data_ID, imm_ID, regWrite_ID, memRead_ID,
             memWrite_ID, memToReg_ID, aluSrc_ID, aluOp_ID, hold_ext, flush_EX,
      output valid_EX, PC_EX, RS1_EX, RS2_EX, RD_EX, useRs1_EX, useRs2_EX,
             rs1Data_EX, rs2Data_EX, imm_EX, regWrite_EX, memRead_EX,
             memWrite_EX, memToReg_EX, aluSrc_EX, aluOp_EX,
             ID_EX_WE, PC_WE, IF_ID_WE, luStallCnt
   );

endinterface

// File: rtl/id_ex_stage_reg_load_use_detect.sv
// Load-use hazard: a valid load in EX writes a register that the valid
// instruction in ID actually reads. x0 never creates a hazard.
module load_use_detect
   import pipe_defs::*;
(
   input  logic              valid_ex,
   input  logic              mem_read_ex,
   input  logic [REG_AW-1:0] rd_ex,
   input  logic              valid_id,
   input  logic              use_rs1_id,
   input  logic [REG_AW-1:0] rs1_id,
   input  logic              use_rs2_id,
   input  logic [REG_AW-1:0] rs2_id,
   output logic              lu
);

   logic rs1_hit;
   logic rs2_hit;

   assign rs1_hit = use_rs1_id && (rs1_id == rd_ex);
   assign rs2_hit = use_rs2_id && (rs2_id == rd_ex);
   assign lu      = valid_ex && mem_read_ex && (rd_ex != '0) && valid_id &&
                    (rs1_hit || rs2_hit);

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use stall, branch flush and external
// freeze; counts inserted load-use bubbles with a saturating counter.
module id_ex_stage_reg
   import pipe_defs::*;
#(
   parameter int CNT_W = LU_CNT_W
) (
   input  logic              CLK,
   input  logic              RSTn,
   id_ex_stage_reg_if.slave  bus
);

   logic             valid_q, valid_d;
   ctrl_t            ctrl_q, ctrl_d;
   data_t            data_q, data_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   ctrl_t      ctrl_id;
   data_t      data_id;
   logic       lu;
   stage_act_e act;
   logic       pc_we, if_id_we, id_ex_we;

   assign ctrl_id = '{reg_write:  bus.regWrite_ID,
                      mem_read:   bus.memRead_ID,
                      mem_write:  bus.memWrite_ID,
                      mem_to_reg: bus.memToReg_ID,
                      alu_src:    bus.aluSrc_ID,
                      alu_op:     bus.aluOp_ID};

   assign data_id = '{pc:       bus.PC_ID,
                      rs1:      bus.RS1_ID,
                      rs2:      bus.RS2_ID,
                      rd:       bus.RD_ID,
                      use_rs1:  bus.useRs1_ID,
                      use_rs2:  bus.useRs2_ID,
                      rs1_data: bus.rs1Data_ID,
                      rs2_data: bus.rs2Data_ID,
                      imm:      bus.imm_ID};

   load_use_detect u_lu (
      .valid_ex    (valid_q),
      .mem_read_ex (ctrl_q.mem_read),
      .rd_ex       (data_q.rd),
      .valid_id    (bus.valid_ID),
      .use_rs1_id  (bus.useRs1_ID),
      .rs1_id      (bus.RS1_ID),
      .use_rs2_id  (bus.useRs2_ID),
      .rs2_id      (bus.RS2_ID),
      .lu          (lu)
   );

   always_comb begin
      if (bus.hold_ext)      act = ACT_HOLD;
      else if (bus.flush_EX) act = ACT_FLUSH;
      else if (lu)           act = ACT_STALL;
      else                   act = ACT_CAPTURE;
   end

   always_comb begin
      // NOTE: every output gets a default first so no path leaves a latch.
      valid_d  = valid_q;
      ctrl_d   = ctrl_q;
      data_d   = data_q;
      cnt_d    = cnt_q;
      pc_we    = 1'b0;
      if_id_we = 1'b0;
      id_ex_we = 1'b0;
      unique case (act)
         ACT_HOLD: ;
         ACT_FLUSH: begin
            valid_d  = 1'b0;
            ctrl_d   = CTRL_BUBBLE;
            data_d   = '0;
            pc_we    = 1'b1;
            if_id_we = 1'b1;
         end
         ACT_STALL: begin
            valid_d = 1'b0;
            ctrl_d  = CTRL_BUBBLE;
            data_d  = '0;
            if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
         end
         ACT_CAPTURE: begin
            valid_d  = bus.valid_ID;
            ctrl_d   = bus.valid_ID ? ctrl_id : CTRL_BUBBLE;
            data_d   = data_id;
            pc_we    = 1'b1;
            if_id_we = 1'b1;
            id_ex_we = bus.valid_ID;
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         valid_q <= 1'b0;
         ctrl_q  <= CTRL_BUBBLE;
         data_q  <= '0;
         cnt_q   <= '0;
      end else begin
         // NOTE: state flops use non-blocking assignments so all registers
         // sample the same pre-edge values.
         valid_q <= valid_d;
         ctrl_q  <= ctrl_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
      end
   end

   // Enables are forced low while reset is asserted so upstream stages freeze.
   assign bus.PC_WE       = pc_we    && RSTn;
   assign bus.IF_ID_WE    = if_id_we && RSTn;
   assign bus.ID_EX_WE    = id_ex_we && RSTn;

   assign bus.valid_EX    = valid_q;
   assign bus.PC_EX       = data_q.pc;
   assign bus.RS1_EX      = data_q.rs1;
   assign bus.RS2_EX      = data_q.rs2;
   assign bus.RD_EX       = data_q.rd;
   assign bus.useRs1_EX   = data_q.use_rs1;
   assign bus.useRs2_EX   = data_q.use_rs2;
   assign bus.rs1Data_EX  = data_q.rs1_data;
   assign bus.rs2Data_EX  = data_q.rs2_data;
   assign bus.imm_EX      = data_q.imm;
   assign bus.regWrite_EX = ctrl_q.reg_write;
   assign bus.memRead_EX  = ctrl_q.mem_read;
   assign bus.memWrite_EX = ctrl_q.mem_write;
   assign bus.memToReg_EX = ctrl_q.mem_to_reg;
   assign bus.aluSrc_EX   = ctrl_q.alu_src;
   assign bus.aluOp_EX    = ctrl_q.alu_op;
   assign bus.luStallCnt  = cnt_q;

endmodule
